flash_word_arbiter: RTL and testbench

Shares the single-byte SPI flash read controller between two requesters (port 0: boot/instruction fetch, port 1: key/config loader) and sequences four byte reads per request into one 32-bit little-endian word. Sits between the requesters and the flash controller's `mem_valid`/`mem_addr`/`mem_data`/`mem_ready` interface, and is the only master of that interface.

---
 rtl/flash_word_arbiter.sv | 136 +++++++++++++
 tb/tb_flash_word_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_word_arbiter.sv
// flash_word_arbiter: round-robin share of a byte-wide SPI flash reader, assembling four reads into a 32-bit LE word.
// Optional one-entry hit buffer when FLASH_ARB_HIT_BUF_EN is defined.
module flash_word_arbiter #(
  parameter int ADDR_W = 24
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [1:0]        rq_valid,
  input  logic [ADDR_W-1:0] rq_addr0,
  input  logic [ADDR_W-1:0] rq_addr1,
  output logic [1:0]        rq_ready,
  output logic [31:0]       rq_rdata,
  output logic              busy,
  output logic              fl_valid,
  output logic [ADDR_W-1:0] fl_addr,
  input  logic [7:0]        fl_data,
  input  logic              fl_ready
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;
  state_e state_q, state_d;
  logic [1:0] cnt_q, cnt_d, ready_q, ready_d;
  logic last_q, last_d, gnt_q, gnt_d, busy_q, busy_d, fv_q, fv_d;
  logic [31:0] word_q, word_d, rdata_q, rdata_d;
  logic [ADDR_W-1:0] fa_q, fa_d, req_base;
  logic req_gnt;
  logic unused_addr_lsbs;
`ifdef FLASH_ARB_HIT_BUF_EN
  logic hb_v_q, hb_v_d;
  logic [ADDR_W-1:0] hb_a_q, hb_a_d;
  logic [31:0] hb_w_q, hb_w_d;
`endif
  assign unused_addr_lsbs = ^{rq_addr0[1:0], rq_addr1[1:0]};
  // last_q holds the previous winner, so a tie goes to the other port
  assign req_gnt  = &rq_valid ? ~last_q : rq_valid[1];
  assign req_base = req_gnt ? {rq_addr1[ADDR_W-1:2], 2'b00} : {rq_addr0[ADDR_W-1:2], 2'b00};
  assign rq_ready = ready_q;
  assign rq_rdata = rdata_q;
  assign busy     = busy_q;
  assign fl_valid = fv_q;
  assign fl_addr  = fa_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = 2'b00;
    last_d  = last_q;
    gnt_d   = gnt_q;
    busy_d  = busy_q;
    fv_d    = 1'b0;
    word_d  = word_q;
    rdata_d = rdata_q;
    fa_d    = fa_q;
`ifdef FLASH_ARB_HIT_BUF_EN
    hb_v_d  = hb_v_q;
    hb_a_d  = hb_a_q;
    hb_w_d  = hb_w_q;
`endif
    case (state_q)
      IDLE: if (|rq_valid) begin
        gnt_d  = req_gnt;
        last_d = req_gnt;
        busy_d = 1'b1;
`ifdef FLASH_ARB_HIT_BUF_EN
        if (hb_v_q && hb_a_q == req_base) begin
          ready_d = req_gnt ? 2'b10 : 2'b01;
          rdata_d = hb_w_q;
          state_d = DONE;
        end else begin
`endif
          fv_d    = 1'b1;
          fa_d    = req_base;
          cnt_d   = 2'd0;
          state_d = WAIT;
`ifdef FLASH_ARB_HIT_BUF_EN
        end
`endif
      end
      WAIT: if (fl_ready) begin
        word_d[{cnt_q, 3'b000} +: 8] = fl_data;
        if (cnt_q != 2'd3) begin
          cnt_d = cnt_q + 2'd1;
          fv_d  = 1'b1;
          fa_d  = fa_q + ADDR_W'(1);
        end else begin
          rdata_d = word_d;
          ready_d = gnt_q ? 2'b10 : 2'b01;
          state_d = DONE;
`ifdef FLASH_ARB_HIT_BUF_EN
          hb_v_d  = 1'b1;
          hb_a_d  = {fa_q[ADDR_W-1:2], 2'b00};
          hb_w_d  = word_d;
`endif
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      ready_q <= 2'b00;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
      busy_q  <= 1'b0;
      fv_q    <= 1'b0;
      word_q  <= 32'd0;
      rdata_q <= 32'd0;
      fa_q    <= '0;
`ifdef FLASH_ARB_HIT_BUF_EN
      hb_v_q  <= 1'b0;
      hb_a_q  <= '0;
      hb_w_q  <= 32'd0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      fv_q    <= fv_d;
      word_q  <= word_d;
      rdata_q <= rdata_d;
      fa_q    <= fa_d;
`ifdef FLASH_ARB_HIT_BUF_EN
      hb_v_q  <= hb_v_d;
      hb_a_q  <= hb_a_d;
      hb_w_q  <= hb_w_d;
`endif
    end
  end
endmodule

// File: tb/tb_flash_word_arbiter.sv
// tb_flash_word_arbiter: randomized bench with a transaction-level reference model and a latency-programmable flash model.
module tb_flash_word_arbiter;
  localparam int AW = 24;
`ifdef FLASH_ARB_HIT_BUF_EN
  localparam bit HIT = 1'b1;
`else
  localparam bit HIT = 1'b0;
`endif
  logic clk = 1'b0, rstn = 1'b0;
  logic v0 = 1'b0, v1 = 1'b0;
  logic [AW-1:0] a0 = '0, a1 = '0;
  logic [1:0] rq_valid, rq_ready;
  logic [31:0] rq_rdata;
  logic busy, fl_valid, fl_ready = 1'b0;
  logic [AW-1:0] fl_addr;
  logic [7:0] fl_data = 8'd0;
  int tests = 0, fails = 0;
  assign rq_valid = {v1, v0};
  always #5 clk = ~clk;

  flash_word_arbiter #(.ADDR_W(AW)) dut (
    .clk(clk), .rstn(rstn), .rq_valid(rq_valid), .rq_addr0(a0), .rq_addr1(a1),
    .rq_ready(rq_ready), .rq_rdata(rq_rdata), .busy(busy), .fl_valid(fl_valid),
    .fl_addr(fl_addr), .fl_data(fl_data), .fl_ready(fl_ready)
  );

  // Flash contents: bytes 0x100..0x103 hold 0x11,0x22,0x33,0x44
  function automatic logic [7:0] fbyte(input logic [AW-1:0] a);
    return 8'(int'(a[1:0]) * 17 + 17) ^ 8'(int'(a[7:2]) * 29) ^ 8'(int'(a[23:8]) - 1);
  endfunction
  function automatic logic [31:0] fword(input logic [AW-1:0] b);
    return {fbyte(b + AW'(3)), fbyte(b + AW'(2)), fbyte(b + AW'(1)), fbyte(b)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  int lat = 2, frem = 0, nbytes = 0, nfv = 0;
  bit fpend = 1'b0;
  logic [AW-1:0] faddr = '0;
  logic [AW-1:0] fa_log[$];
  initial forever begin
    @(negedge clk);
    if (rstn && fl_valid) begin
      check("one_outstanding", 32'(fpend), 32'd0);
      fpend = 1'b1; frem = lat; faddr = fl_addr; nfv++;
      fa_log.push_back(fl_addr);
    end
  end
  initial forever begin
    @(posedge clk); #2;
    fl_ready = 1'b0;
    if (!rstn) fpend = 1'b0;
    else if (fpend) begin
      frem--;
      if (frem == 0) begin
        fl_ready = 1'b1; fl_data = fbyte(faddr); fpend = 1'b0; nbytes++;
      end
    end
  end

  // Transaction-level reference: which port is served, which byte address is due, and when the word appears
  bit m_act = 1'b0, m_done = 1'b0, m_port = 1'b0, m_last = 1'b1, hb_v = 1'b0;
  int m_got = 0;
  logic [AW-1:0] m_base = '0, hb_a = '0;
  logic [1:0] e_ready = 2'b00;
  logic [31:0] e_rdata = 32'd0;
  bit e_busy = 1'b0, e_fv = 1'b0;
  logic [AW-1:0] e_fa = '0;
  int grants[$];
  task automatic complete();
    e_ready = m_port ? 2'b10 : 2'b01;
    e_rdata = fword(m_base);
    m_act = 1'b0; m_done = 1'b1; hb_v = 1'b1; hb_a = m_base;
  endtask
  initial forever begin
    @(posedge clk or negedge rstn);
    if (!rstn) begin
      m_act = 1'b0; m_done = 1'b0; m_last = 1'b1; hb_v = 1'b0;
      e_ready = 2'b00; e_rdata = 32'd0; e_busy = 1'b0; e_fv = 1'b0; e_fa = '0;
    end else if (m_done) begin
      m_done = 1'b0; e_ready = 2'b00; e_busy = 1'b0;
    end else if (m_act) begin
      e_fv = 1'b0;
      if (fl_ready) begin
        m_got++;
        if (m_got < 4) begin e_fv = 1'b1; e_fa = m_base + AW'(m_got); end
        else complete();
      end
    end else if (rq_valid != 2'b00) begin
      m_port = (rq_valid == 2'b11) ? !m_last : rq_valid[1];
      m_last = m_port;
      grants.push_back(int'(m_port));
      m_base = (m_port ? a1 : a0) & ~AW'(3);
      e_busy = 1'b1;
      if (HIT && hb_v && hb_a == m_base) complete();
      else begin m_act = 1'b1; m_got = 0; e_fv = 1'b1; e_fa = m_base; end
    end
  end

  int r0cnt = 0, r1cnt = 0;
  int ord[$];
  logic [31:0] last_w0 = 32'd0, last_w1 = 32'd0;
  bit seen0 = 1'b0, seen1 = 1'b0;
  initial forever begin
    @(negedge clk);
    check("rq_ready", 32'(rq_ready), 32'(e_ready));
    check("busy", 32'(busy), 32'(e_busy));
    check("fl_valid", 32'(fl_valid), 32'(e_fv));
    if (e_ready != 2'b00) check("rq_rdata", rq_rdata, e_rdata);
    if (m_act) check("fl_addr", 32'(fl_addr), 32'(e_fa));
    if (rq_ready[0]) begin r0cnt++; last_w0 = rq_rdata; ord.push_back(0); seen0 = 1'b1; end
    if (rq_ready[1]) begin r1cnt++; last_w1 = rq_rdata; ord.push_back(1); seen1 = 1'b1; end
  end

  // Requesters: hold valid+addr until ready, then move to the next queued address at once
  logic [AW-1:0] q0[$], q1[$];
  bit drop0 = 1'b0;
  initial forever begin
    @(posedge clk); #2;
    if (!rstn) begin
      v0 = 1'b0; v1 = 1'b0; q0.delete(); q1.delete(); seen0 = 1'b0; seen1 = 1'b0;
    end else begin
      if (seen0) begin seen0 = 1'b0; if (v0) begin void'(q0.pop_front()); v0 = 1'b0; end end
      if (seen1) begin seen1 = 1'b0; if (v1) begin void'(q1.pop_front()); v1 = 1'b0; end end
      if (drop0 && v0) begin drop0 = 1'b0; v0 = 1'b0; void'(q0.pop_front()); end
      if (!v0 && q0.size() > 0) begin v0 = 1'b1; a0 = q0[0]; end
      if (!v1 && q1.size() > 0) begin v1 = 1'b1; a1 = q1[0]; end
    end
  end

  task automatic wait_idle(input int maxc);
    int c = 0;
    while ((q0.size() > 0 || q1.size() > 0 || v0 || v1 || m_act || m_done || busy) && c < maxc) begin
      @(posedge clk); c++;
    end
    check("idle_timeout", 32'(c >= maxc), 32'd0);
    repeat (2) @(posedge clk);
  endtask
  task automatic hold_reset();
    @(posedge clk); #2 rstn = 1'b0;
    #1;
    check("rst_ready", 32'(rq_ready), 32'd0);
    check("rst_rdata", rq_rdata, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_fl_valid", 32'(fl_valid), 32'd0);
    check("rst_fl_addr", 32'(fl_addr), 32'd0);
    repeat (3) @(posedge clk);
    #2 rstn = 1'b1;
    repeat (2) @(posedge clk);
  endtask
  task automatic wait_bytes(input int target);
    int c = 0;
    while (nbytes < target && c < 1000) begin @(posedge clk); c++; end
    check("byte_timeout", 32'(c >= 1000), 32'd0);
  endtask

  int s0, s1, sf, n;
  int exp_ord[4] = '{0, 1, 0, 1};
  initial begin
    hold_reset();
    // single port-0 read with slow flash
    lat = 70; sf = nfv; s0 = r0cnt; s1 = r1cnt; fa_log.delete();
    q0.push_back(24'h000100);
    wait_idle(2000);
    check("t1_word", last_w0, 32'h44332211);
    check("t1_model_word", fword(24'h000100), 32'h44332211);
    check("t1_nfv", 32'(nfv - sf), 32'd4);
    check("t1_r0", 32'(r0cnt - s0), 32'd1);
    check("t1_r1", 32'(r1cnt - s1), 32'd0);
    for (int k = 0; k < 4 && k < fa_log.size(); k++) check("t1_addr", 32'(fa_log[k]), 32'h100 + 32'(k));
    // simultaneous requests after reset, each port re-requesting right away
    hold_reset();
    lat = 2; grants.delete(); ord.delete();
    q0.push_back(24'h000010); q0.push_back(24'h000030);
    q1.push_back(24'h000020); q1.push_back(24'h000040);
    wait_idle(500);
    check("t2_n", 32'(ord.size()), 32'd4);
    for (int k = 0; k < 4 && k < ord.size(); k++) check("t2_dut_order", 32'(ord[k]), 32'(exp_ord[k]));
    for (int k = 0; k < 4 && k < grants.size(); k++) check("t2_model_order", 32'(grants[k]), 32'(exp_ord[k]));
    // top word, no wrap
    fa_log.delete();
    q1.push_back(24'hFFFFFE);
    wait_idle(500);
    check("t3_n", 32'(fa_log.size()), 32'd4);
    for (int k = 0; k < 4 && k < fa_log.size(); k++) check("t3_addr", 32'(fa_log[k]), 32'hFFFFFC + 32'(k));
    check("t3_word", last_w1, fword(24'hFFFFFC));
    // reset after the second byte aborts without a completion pulse
    lat = 3; s0 = r0cnt; n = nbytes;
    q0.push_back(24'h000400);
    wait_bytes(n + 2);
    hold_reset();
    check("t4_no_ready", 32'(r0cnt - s0), 32'd0);
    fa_log.delete();
    q0.push_back(24'h000400);
    wait_idle(500);
    check("t4_n", 32'(fa_log.size()), 32'd4);
    if (fa_log.size() > 0) check("t4_first", 32'(fa_log[0]), 32'h400);
    check("t4_word", last_w0, fword(24'h000400));
    check("t4_r0", 32'(r0cnt - s0), 32'd1);
    // requester drops valid after the first byte
    s0 = r0cnt; n = nbytes;
    q0.push_back(24'h000500);
    wait_bytes(n + 1);
    drop0 = 1'b1;
    wait_idle(500);
    check("t5_r0", 32'(r0cnt - s0), 32'd1);
    check("t5_word", last_w0, fword(24'h000500));
    // same word from the other port: served from the buffer when enabled
    q0.push_back(24'h000200);
    wait_idle(500);
    sf = nfv;
    q1.push_back(24'h000200);
    wait_idle(500);
    check("t6_nfv", 32'(nfv - sf), HIT ? 32'd0 : 32'd4);
    check("t6_word", last_w1, fword(24'h000200));
    hold_reset();
    sf = nfv;
    q1.push_back(24'h000200);
    wait_idle(500);
    check("t6_after_rst_nfv", 32'(nfv - sf), 32'd4);
    // randomized traffic with a small address pool to provoke buffer hits
    for (int i = 0; i < 60; i++) begin
      lat = $urandom_range(1, 4);
      if ($urandom_range(0, 1) == 1 && q0.size() < 3)
        q0.push_back($urandom_range(0, 2) == 0 ? AW'($urandom) : AW'(32'h200 + 4 * $urandom_range(0, 2)));
      if ($urandom_range(0, 1) == 1 && q1.size() < 3)
        q1.push_back($urandom_range(0, 2) == 0 ? AW'($urandom) : AW'(32'h200 + 4 * $urandom_range(0, 2)));
      repeat ($urandom_range(0, 25)) @(posedge clk);
    end
    wait_idle(3000);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    fails++;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
